// File: rtl/button_conditioner.sv
// Button/switch front end for the RTC time-set UI: 2-flop sync, tick-sampled debounce, press pulses.
// Define BTN_AUTOREPEAT_EN to add held-button auto-repeat pulses.
module button_conditioner #(
   parameter int NUM_BTN      = 3,
   parameter int TICK_MAX     = 49999,
   parameter int SHIFT_LEN    = 8,
   parameter int REPEAT_DELAY = 500,
   parameter int REPEAT_RATE  = 100
) (
   input  logic               clock50MHz,
   input  logic               resetn,
   input  logic [NUM_BTN-1:0] btn_n_raw,
   input  logic               man_switch_raw,
   output logic               tick_1k,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_pulse,
   output logic               man_mode
);

   localparam int TW = $clog2(TICK_MAX + 1);

   logic [TW-1:0]      tick_cnt;
   logic [NUM_BTN-1:0] btn_sync1, btn_sync2;
   logic               sw_sync1, sw_sync2;
   logic [NUM_BTN:0]   act;
   logic [NUM_BTN:0]   deb;
   logic [NUM_BTN-1:0] level_q;
   logic [NUM_BTN-1:0] rep;

   always_ff @(posedge clock50MHz or negedge resetn) begin
      if (!resetn) begin
         tick_cnt <= '0;
      end else if (tick_cnt == TW'(TICK_MAX)) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   assign tick_1k = (tick_cnt == TW'(TICK_MAX));

   always_ff @(posedge clock50MHz or negedge resetn) begin
      if (!resetn) begin
         btn_sync1 <= '1;
         btn_sync2 <= '1;
         sw_sync1  <= 1'b0;
         sw_sync2  <= 1'b0;
      end else begin
         btn_sync1 <= btn_n_raw;
         btn_sync2 <= btn_sync1;
         sw_sync1  <= man_switch_raw;
         sw_sync2  <= sw_sync1;
      end
   end

   // Active-high view of every input; the top bit is the manual-set switch.
   assign act = {sw_sync2, ~btn_sync2};

   for (genvar i = 0; i <= NUM_BTN; i++) begin : g_deb
      logic [SHIFT_LEN-1:0] shreg;
      logic [SHIFT_LEN-1:0] shnext;
      logic                 lvl;

      assign shnext = {shreg[SHIFT_LEN-2:0], act[i]};

      always_ff @(posedge clock50MHz or negedge resetn) begin
         if (!resetn) begin
            shreg <= '0;
            lvl   <= 1'b0;
         end else if (tick_1k) begin
            shreg <= shnext;
            if (&shnext) begin
               lvl <= 1'b1;
            end else if (~|shnext) begin
               lvl <= 1'b0;
            end
         end
      end

      assign deb[i] = lvl;
   end

   assign btn_level = deb[NUM_BTN-1:0];
   assign man_mode  = deb[NUM_BTN];

`ifdef BTN_AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_DELAY + 1);

   // Reloading DELAY-RATE after each repeat gives the periodic cadence without wrapping.
   for (genvar i = 0; i < NUM_BTN; i++) begin : g_rep
      logic [RW-1:0] hold_cnt;
      logic          hit;

      assign hit    = (hold_cnt == RW'(REPEAT_DELAY - 1));
      assign rep[i] = btn_level[i] & tick_1k & hit;

      always_ff @(posedge clock50MHz or negedge resetn) begin
         if (!resetn) begin
            hold_cnt <= '0;
         end else if (!btn_level[i]) begin
            hold_cnt <= '0;
         end else if (tick_1k) begin
            if (hit) begin
               hold_cnt <= RW'(REPEAT_DELAY - REPEAT_RATE);
            end else begin
               hold_cnt <= hold_cnt + 1'b1;
            end
         end
      end
   end
`else
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
   assign rep = '0;
`endif

   always_ff @(posedge clock50MHz or negedge resetn) begin
      if (!resetn) begin
         level_q   <= '0;
         btn_pulse <= '0;
      end else begin
         level_q   <= btn_level;
         btn_pulse <= ((btn_level & ~level_q) | rep) & {NUM_BTN{man_mode}};
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random holds against a queue-based model.
`timescale 1ns/1ps
module tb_button_conditioner;

   localparam int NUM_BTN      = 3;
   localparam int TICK_MAX     = 9;
   localparam int SHIFT_LEN    = 4;
   localparam int REPEAT_DELAY = 5;
   localparam int REPEAT_RATE  = 2;
   localparam int TICK_PERIOD  = TICK_MAX + 1;
   localparam int SETTLE       = 60;

   logic               clock50MHz = 1'b0;
   logic               resetn = 1'b0;
   logic [NUM_BTN-1:0] btn_n_raw = '1;
   logic               man_switch_raw = 1'b0;
   logic               tick_1k;
   logic [NUM_BTN-1:0] btn_level;
   logic [NUM_BTN-1:0] btn_pulse;
   logic               man_mode;

   button_conditioner #(
      .NUM_BTN(NUM_BTN), .TICK_MAX(TICK_MAX), .SHIFT_LEN(SHIFT_LEN),
      .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
   ) dut (
      .clock50MHz(clock50MHz), .resetn(resetn), .btn_n_raw(btn_n_raw),
      .man_switch_raw(man_switch_raw), .tick_1k(tick_1k), .btn_level(btn_level),
      .btn_pulse(btn_pulse), .man_mode(man_mode)
   );

   // ---------------- clock ----------------
   always #10 clock50MHz = ~clock50MHz;

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Inputs reach the debouncer two clocks late; each tick appends one sample per input
   // to a window of the last SHIFT_LEN samples, and the level follows a unanimous window.
   int                 e;
   logic [NUM_BTN:0]   dl[$];
   bit                 samp_q[NUM_BTN+1][$];
   logic [NUM_BTN:0]   m_lvl;
   logic [NUM_BTN:0]   m_prev;
   logic [NUM_BTN-1:0] m_pulse;
   int                 hold_t[NUM_BTN];

   always @(posedge clock50MHz or negedge resetn) begin : model
      logic [NUM_BTN:0]   seen, cur;
      logic [NUM_BTN-1:0] rise, rep;
      logic               is_tick;
      int                 ones;
      if (!resetn) begin
         e = 0;
         dl.delete();
         dl.push_back('0);
         dl.push_back('0);
         for (int j = 0; j <= NUM_BTN; j++) begin
            samp_q[j].delete();
            for (int k = 0; k < SHIFT_LEN; k++) samp_q[j].push_back(1'b0);
         end
         m_lvl   = '0;
         m_prev  = '0;
         m_pulse = '0;
         for (int j = 0; j < NUM_BTN; j++) hold_t[j] = 0;
      end else begin
         is_tick = ((e % TICK_PERIOD) == TICK_MAX);
         e++;
         seen = dl.pop_front();
         dl.push_back({man_switch_raw, ~btn_n_raw});
         cur  = m_lvl;
         rise = cur[NUM_BTN-1:0] & ~m_prev[NUM_BTN-1:0];
         rep  = '0;
`ifdef BTN_AUTOREPEAT_EN
         for (int j = 0; j < NUM_BTN; j++) begin
            if (!cur[j]) begin
               hold_t[j] = 0;
            end else if (is_tick) begin
               hold_t[j]++;
               if (hold_t[j] >= REPEAT_DELAY && ((hold_t[j] - REPEAT_DELAY) % REPEAT_RATE) == 0)
                  rep[j] = 1'b1;
            end
         end
`endif
         m_pulse = (rise | rep) & {NUM_BTN{cur[NUM_BTN]}};
         m_prev  = cur;
         if (is_tick) begin
            for (int j = 0; j <= NUM_BTN; j++) begin
               samp_q[j].push_back(seen[j]);
               if (samp_q[j].size() > SHIFT_LEN) void'(samp_q[j].pop_front());
               ones = 0;
               foreach (samp_q[j][k]) ones += int'(samp_q[j][k]);
               if (ones == SHIFT_LEN) m_lvl[j] = 1'b1;
               else if (ones == 0) m_lvl[j] = 1'b0;
            end
         end
      end
   end

   // Continuous comparison of every output against the model, away from the active edge.
   always @(negedge clock50MHz) begin
      if (resetn) begin
         check_val("tick_1k", 32'(tick_1k), 32'((e % TICK_PERIOD) == TICK_MAX));
         check_val("btn_level", 32'(btn_level), 32'(m_lvl[NUM_BTN-1:0]));
         check_val("man_mode", 32'(man_mode), 32'(m_lvl[NUM_BTN]));
         check_val("btn_pulse", 32'(btn_pulse), 32'(m_pulse));
      end
   end

   // ---------------- monitor counters for directed checks ----------------
   int pulse_cnt[NUM_BTN] = '{default: 0};
   int tick_seen = 0;
   int lvl1_cycles = 0;
   int cnt_101 = 0;
   int cyc = 0;
   int pulse1_q[$];

   always @(negedge clock50MHz) begin
      cyc++;
      if (resetn) begin
         for (int i = 0; i < NUM_BTN; i++) if (btn_pulse[i]) pulse_cnt[i]++;
         if (tick_1k) tick_seen++;
         if (btn_level[1]) lvl1_cycles++;
         if (btn_pulse == 3'b101) cnt_101++;
         if (btn_pulse[1]) pulse1_q.push_back(cyc);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clocks(input int n);
      repeat (n) @(negedge clock50MHz);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_tick"}, 32'(tick_1k), 32'(0));
      check_val({tag, "_level"}, 32'(btn_level), 32'(0));
      check_val({tag, "_pulse"}, 32'(btn_pulse), 32'(0));
      check_val({tag, "_man"}, 32'(man_mode), 32'(0));
   endtask

   // ---------------- stimulus ----------------
   int t0, p0, p1, p2, lat, c0, l0, start_idx;

   initial begin
      resetn = 1'b0;
      btn_n_raw = '1;
      man_switch_raw = 1'b0;
      clocks(3);
      check_all_zero("reset");
      resetn = 1'b1;

      t0 = tick_seen;
      clocks(100);
      check_val("idle_tick_count", 32'(tick_seen - t0), 32'(100 / TICK_PERIOD));
      check_val("idle_level", 32'(btn_level), 32'(0));

      // Clean press of button 0 in manual mode.
      man_switch_raw = 1'b1;
      clocks(SETTLE);
      check_val("man_mode_set", 32'(man_mode), 32'(1));
      p0 = pulse_cnt[0];
      btn_n_raw[0] = 1'b0;
      lat = 0;
      while (!btn_level[0] && lat < 100) begin
         clocks(1);
         lat++;
      end
      check_val("press_latency_ok", 32'(lat <= SHIFT_LEN * TICK_PERIOD + 3), 32'(1));
      if (lat < 60) clocks(60 - lat);
      btn_n_raw[0] = 1'b1;
      clocks(SETTLE);
      check_val("release_level0", 32'(btn_level[0]), 32'(0));
`ifndef BTN_AUTOREPEAT_EN
      check_val("press_one_pulse", 32'(pulse_cnt[0] - p0), 32'(1));
`endif

      // Bouncing button 1 never qualifies.
      p1 = pulse_cnt[1];
      l0 = lvl1_cycles;
      for (int k = 0; k < 200; k++) begin
         if (k % 15 == 0) btn_n_raw[1] = ~btn_n_raw[1];
         clocks(1);
      end
      btn_n_raw[1] = 1'b1;
      clocks(SETTLE);
      check_val("bounce_level1", 32'(lvl1_cycles - l0), 32'(0));
      check_val("bounce_pulse1", 32'(pulse_cnt[1] - p1), 32'(0));

      // Gated press of button 2, then enabling manual mode while it is held.
      man_switch_raw = 1'b0;
      clocks(SETTLE);
      check_val("man_mode_clear", 32'(man_mode), 32'(0));
      p2 = pulse_cnt[2];
      btn_n_raw[2] = 1'b0;
      clocks(SETTLE);
      check_val("gated_level2", 32'(btn_level[2]), 32'(1));
      check_val("gated_pulse2", 32'(pulse_cnt[2] - p2), 32'(0));
      man_switch_raw = 1'b1;
      clocks(SETTLE);
      check_val("mode_on_held_man", 32'(man_mode), 32'(1));
`ifndef BTN_AUTOREPEAT_EN
      check_val("mode_on_held_nopulse", 32'(pulse_cnt[2] - p2), 32'(0));
`endif
      btn_n_raw[2] = 1'b1;
      clocks(SETTLE);

      // Simultaneous presses on buttons 0 and 2.
      c0 = cnt_101;
      btn_n_raw = 3'b010;
      clocks(80);
      check_val("simul_101", 32'((cnt_101 - c0) > 0), 32'(1));
      btn_n_raw = 3'b111;
      clocks(SETTLE);

      // Reset mid-hold, then the held press is recognised once after release.
      btn_n_raw[0] = 1'b0;
      clocks(SETTLE);
      resetn = 1'b0;
      #1;
      check_all_zero("midreset");
      clocks(3);
      p0 = pulse_cnt[0];
      resetn = 1'b1;
      clocks(80);
      check_val("post_reset_level0", 32'(btn_level[0]), 32'(1));
      check_val("post_reset_man", 32'(man_mode), 32'(1));
      check_val("post_reset_pulse0", 32'(pulse_cnt[0] - p0), 32'(1));
      btn_n_raw[0] = 1'b1;
      clocks(SETTLE);

      // Random holds and mode changes, checked cycle by cycle against the model.
      for (int r = 0; r < 40; r++) begin
         btn_n_raw = NUM_BTN'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) man_switch_raw = ~man_switch_raw;
         clocks($urandom_range(5, 80));
      end
      btn_n_raw = '1;
      man_switch_raw = 1'b1;
      clocks(SETTLE);

`ifdef BTN_AUTOREPEAT_EN
      // Held button 1: press pulse, first repeat after REPEAT_DELAY ticks, then every REPEAT_RATE.
      start_idx = pulse1_q.size();
      btn_n_raw[1] = 1'b0;
      lat = 0;
      while (!btn_level[1] && lat < 100) begin
         clocks(1);
         lat++;
      end
      check_val("rep_level_latency_ok", 32'(lat <= SHIFT_LEN * TICK_PERIOD + 3), 32'(1));
      clocks(20 * TICK_PERIOD);
      check_val("rep_pulse_count", 32'(pulse1_q.size() - start_idx),
                32'(1 + (20 - REPEAT_DELAY) / REPEAT_RATE + 1));
      if (pulse1_q.size() - start_idx >= 2)
         check_val("rep_first_gap", 32'(pulse1_q[start_idx+1] - pulse1_q[start_idx]),
                   32'(REPEAT_DELAY * TICK_PERIOD - 1));
      for (int k = start_idx + 2; k < pulse1_q.size(); k++)
         check_val("rep_gap", 32'(pulse1_q[k] - pulse1_q[k-1]), 32'(REPEAT_RATE * TICK_PERIOD));
      resetn = 1'b0;
      #1;
      check_all_zero("rep_reset");
      clocks(3);
      btn_n_raw = '1;
      resetn = 1'b1;
      clocks(SETTLE);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
